add3_pipe_arbiter: RTL

Round-robin arbiter and sequencer that shares one fixed-latency pipelined three-operand adder (out = x1 + y1 + z1, 3-cycle latency, no stall, no valid) among NUM_REQ requesters. It accepts at most one request per cycle, drives the adder operands from registers, and tracks issued operations through a tag pipeline. Each result returns to its originating requester as a one-cycle response pulse. It sits between the requesting engines and the adder datapath; the adder itself is instantiated outside this block.

---
 rtl/add3_pipe_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/add3_pipe_arbiter.sv
// Round-robin arbiter and sequencer that shares one external 3-operand adder
// among NUM_REQ requesters, tracking each issued operation with a tag pipeline.
module add3_pipe_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]          req_x,
  input  logic [NUM_REQ*WIDTH-1:0]          req_y,
  input  logic [NUM_REQ*WIDTH-1:0]          req_z,
  output logic [WIDTH-1:0]                  add_x1,
  output logic [WIDTH-1:0]                  add_y1,
  output logic [WIDTH-1:0]                  add_z1,
  input  logic [WIDTH-1:0]                  add_out,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [WIDTH-1:0]                  rsp_data,
  output logic                              busy,
  output logic [$clog2(LATENCY+2)-1:0]      inflight
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LATENCY+2);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_id;
  logic             grant_found;
  logic [PTR_W-1:0] cand;
  logic             handshake;
  logic             rsp_fire;

  // Tag stage 0 lines up with add_* and stage LATENCY lines up with add_out.
  logic             tag_valid [LATENCY+1];
  logic [PTR_W-1:0] tag_id    [LATENCY+1];

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (enable && grant_found && !rst)
      req_ready = NUM_REQ'(1) << grant_id;
  end

  assign handshake = |(req_valid & req_ready);
  assign rsp_fire  = tag_valid[LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      add_x1 <= '0;
      add_y1 <= '0;
      add_z1 <= '0;
    end else if (handshake) begin
      ptr    <= (grant_id == PTR_W'(NUM_REQ-1)) ? '0 : grant_id + PTR_W'(1);
      add_x1 <= req_x[grant_id*WIDTH +: WIDTH];
      add_y1 <= req_y[grant_id*WIDTH +: WIDTH];
      add_z1 <= req_z[grant_id*WIDTH +: WIDTH];
    end else begin
      add_x1 <= '0;
      add_y1 <= '0;
      add_z1 <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= LATENCY; s++) begin
        tag_valid[s] <= 1'b0;
        tag_id[s]    <= '0;
      end
    end else begin
      tag_valid[0] <= handshake;
      tag_id[0]    <= handshake ? grant_id : '0;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (rsp_fire) begin
      rsp_valid = NUM_REQ'(1) << tag_id[LATENCY];
      rsp_data  = add_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({handshake, rsp_fire})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign busy = (inflight != '0);

endmodule
